attempt_lockout_ctrl: RTL
=========================

Name: attempt_lockout_ctrl

Overview:
- Clocked, parametrised successor to the combinational wrong-password counter.
- Counts consecutive failed attempts and enforces a timed lockout after MAX_TRIES failures. Lockout durations escalate; the block raises a latched intruder alarm after MAX_LOCKS lockouts.
- Sits between the password comparator and the door actuator / alarm driver. Fire alarm overrides everything and forces the door open.

Parameters:
- CNT_W, 3, width of fail_count; MAX_TRIES must be <= 2**CNT_W-1.
- MAX_TRIES, 3, consecutive failures that trigger a lockout (>=1).
- LOCK_CYCLES, 16, base lockout length in clk cycles (>=1).
- MAX_LOCKS, 3, lockouts before alarm (>=1).
- TMR_W, 8, lockout timer width; must hold LOCK_CYCLES<<(MAX_LOCKS-1) or the value saturates.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- attempt_valid  in  1  one-cycle strobe: a password entry completed.
- pass_ok  in  1  qualifies attempt_valid; 1 = correct password.
- fire_alarm  in  1  level; emergency override.
- alarm_disable  in  1  level/pulse; supervisor clear of alarm and escalation.
- unlock  out  1  one-cycle pulse on accepted correct entry; held high during FIRE.
- fail_count  out  CNT_W  consecutive failures since last clear.
- locked  out  1  high in LOCKED state.
- lock_remaining  out  TMR_W  cycles left in the current lockout; 0 otherwise.
- lock_level  out  $clog2(MAX_LOCKS+1)  number of lockouts since last clear.
- alarm  out  1  latched intruder alarm.
- rejected  out  1  one-cycle pulse when an attempt arrives in LOCKED, ALARM or FIRE.

Behaviour:
- Reset values (async, immediate): state IDLE; all outputs 0; internal timer 0.
- States: IDLE, LOCKED, ALARM, FIRE. All outputs are registered; each response appears the cycle after the causing input.
- Priority per cycle: fire_alarm > alarm_disable > attempt_valid > timer.
- Any state with fire_alarm=1 -> FIRE: fail_count=0, lock_level=0, alarm=0, timer=0, unlock=1 held.
- FIRE with fire_alarm=0 -> IDLE; unlock drops the same edge.
- alarm_disable=1 in any non-FIRE state -> IDLE with fail_count=0, lock_level=0, alarm=0, timer=0. Any attempt in the same cycle is ignored (no rejected pulse).
- IDLE, attempt_valid and pass_ok:
  - unlock pulse; fail_count=0.
  - lock_level is retained; only alarm_disable clears escalation.
- IDLE, attempt_valid and !pass_ok: fail_count+1. If the new value equals MAX_TRIES:
  - If lock_level+1 == MAX_LOCKS -> ALARM: alarm=1, lock_level=MAX_LOCKS, fail_count=0.
  - Else -> LOCKED: lock_level+1, fail_count=0, timer=min(LOCK_CYCLES<<lock_level_old, 2**TMR_W-1).
- fail_count never exceeds MAX_TRIES-1 in IDLE; no wrap-around.
- LOCKED:
  - Timer decrements each cycle; lock_remaining mirrors the timer.
  - When the timer is 1 it decrements to 0 and the state -> IDLE (locked=0) that edge. Lockout length is exactly the loaded value in cycles.
- LOCKED/ALARM with attempt_valid: rejected pulse; no count change.
- ALARM: held until alarm_disable or fire_alarm.
- Reset asserted mid-lockout or mid-alarm clears everything to IDLE immediately.
- attempt_valid held high for N cycles counts as N attempts.

Decomposition:
- Shared package lock_pkg: state enum (IDLE, LOCKED, ALARM, FIRE) and the lock_level width function. The package is reused by the keypad and alarm-driver blocks.
- One sub-module: lock_timer, a loadable saturating down-counter with a load port, a zero flag and async reset.

Test Plan:
- MAX_TRIES=3, LOCK_CYCLES=16: three wrong attempts -> after the third, locked=1, lock_remaining=16, fail_count=0. locked=0 exactly 16 cycles later.
- Second lockout cycle: three more wrong attempts -> lock_remaining=32, lock_level=2. Third round -> alarm=1, locked=0, lock_level=3.
- Two wrong then one correct -> unlock pulse 1 cycle, fail_count 2->0, lock_level unchanged.
- Attempt during LOCKED -> rejected=1 for one cycle; lock_remaining keeps counting, fail_count stays 0.
- fire_alarm mid-lockout (remaining=7) -> next cycle FIRE: unlock=1, locked=0, lock_level=0. Drop fire_alarm -> IDLE, unlock=0.
- alarm_disable and attempt_valid together in ALARM -> IDLE, alarm=0, no rejected pulse. Async rst mid-LOCKED -> all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types for the door-lock blocks (lockout controller, keypad, alarm driver).
package lock_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLocked,
    StAlarm,
    StFire
  } lock_state_e;

  // Width needed to hold a lockout count from 0 up to and including max_locks.
  function automatic int unsigned lock_level_width(input int unsigned max_locks);
    return $clog2(max_locks + 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter for lockout durations; stops at zero rather than wrapping.
module lock_timer #(
  parameter int unsigned TMR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [TMR_W-1:0] count_o,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/attempt_lockout_ctrl.sv
// Failed-attempt counter with escalating timed lockouts, intruder alarm and fire override.
module attempt_lockout_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned MAX_LOCKS   = 3,
  parameter int unsigned TMR_W       = 8,
  localparam int unsigned LVL_W      = lock_level_width(MAX_LOCKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             attempt_valid,
  input  logic             pass_ok,
  input  logic             fire_alarm,
  input  logic             alarm_disable,
  output logic             unlock,
  output logic [CNT_W-1:0] fail_count,
  output logic             locked,
  output logic [TMR_W-1:0] lock_remaining,
  output logic [LVL_W-1:0] lock_level,
  output logic             alarm,
  output logic             rejected
);

  localparam logic [63:0] TmrMax = (64'd1 << TMR_W) - 64'd1;

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] fail_q, fail_d, fail_inc;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             alarm_q, alarm_d;
  logic             unlock_q, unlock_d;
  logic             rejected_q, rejected_d;

  logic             tmr_clear, tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val, tmr_cnt;
  logic [63:0]      lock_len;

  // Lockout length doubles per previous lockout and saturates at the timer's range.
  assign lock_len = 64'(LOCK_CYCLES) << lvl_q;
  assign tmr_val  = (lock_len > TmrMax) ? TMR_W'(TmrMax) : TMR_W'(lock_len);
  assign fail_inc = fail_q + CNT_W'(1);

  lock_timer #(
    .TMR_W (TMR_W)
  ) u_lock_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .count_o    (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  // Next-state decode: fire > alarm_disable > attempt > timer expiry.
  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    lvl_d      = lvl_q;
    alarm_d    = alarm_q;
    unlock_d   = 1'b0;
    rejected_d = 1'b0;
    tmr_clear  = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = (state_q == StLocked);

    if (fire_alarm) begin
      state_d    = StFire;
      fail_d     = '0;
      lvl_d      = '0;
      alarm_d    = 1'b0;
      unlock_d   = 1'b1;
      tmr_clear  = 1'b1;
      rejected_d = attempt_valid && (state_q == StFire);
    end else if (state_q == StFire) begin
      state_d    = StIdle;
      rejected_d = attempt_valid;
    end else if (alarm_disable) begin
      state_d   = StIdle;
      fail_d    = '0;
      lvl_d     = '0;
      alarm_d   = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (attempt_valid) begin
            if (pass_ok) begin
              unlock_d = 1'b1;
              fail_d   = '0;
            end else if (fail_inc == CNT_W'(MAX_TRIES)) begin
              fail_d = '0;
              if (lvl_q == LVL_W'(MAX_LOCKS - 1)) begin
                state_d = StAlarm;
                alarm_d = 1'b1;
                lvl_d   = LVL_W'(MAX_LOCKS);
              end else begin
                state_d  = StLocked;
                lvl_d    = lvl_q + LVL_W'(1);
                tmr_load = 1'b1;
              end
            end else begin
              fail_d = fail_inc;
            end
          end
        end
        StLocked: begin
          rejected_d = attempt_valid;
          // Leave on the edge where the timer reaches zero; zero flag guards a stale 0.
          if ((tmr_cnt == TMR_W'(1)) || tmr_zero) begin
            state_d = StIdle;
          end
        end
        StAlarm: begin
          rejected_d = attempt_valid;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fail_q     <= '0;
      lvl_q      <= '0;
      alarm_q    <= 1'b0;
      unlock_q   <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      lvl_q      <= lvl_d;
      alarm_q    <= alarm_d;
      unlock_q   <= unlock_d;
      rejected_q <= rejected_d;
    end
  end

  assign unlock         = unlock_q;
  assign fail_count     = fail_q;
  assign locked         = (state_q == StLocked);
  assign lock_remaining = tmr_cnt;
  assign lock_level     = lvl_q;
  assign alarm          = alarm_q;
  assign rejected       = rejected_q;

endmodule
